// File: rtl/mem_req_arbiter_if.sv
// Requester/memory-side bundle of the I/D memory request arbiter.
// slave = arbiter view, master = requesters plus AXI master front-end view.
interface mem_req_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 128
);
    logic              i_req_i;
    logic [ADDR_W-1:0] i_addr_i;
    logic [DATA_W-1:0] i_rdata_o;
    logic              i_done_o;

    logic              d_req_i;
    logic              d_rw_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic [DATA_W-1:0] d_rdata_o;
    logic              d_done_o;

    logic              mem_valid_req_o;
    logic              mem_rw_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic [DATA_W-1:0] mem_data_i;
    logic              mem_rd_over_i;
    logic              mem_wr_over_i;

    logic [1:0]        grant_o;
    logic              busy_o;

    modport slave (
        input  i_req_i, i_addr_i, d_req_i, d_rw_i, d_addr_i, d_wdata_i,
               mem_data_i, mem_rd_over_i, mem_wr_over_i,
        output i_rdata_o, i_done_o, d_rdata_o, d_done_o,
               mem_valid_req_o, mem_rw_o, mem_addr_o, mem_data_o,
               grant_o, busy_o
    );

    modport master (
        output i_req_i, i_addr_i, d_req_i, d_rw_i, d_addr_i, d_wdata_i,
               mem_data_i, mem_rd_over_i, mem_wr_over_i,
        input  i_rdata_o, i_done_o, d_rdata_o, d_done_o,
               mem_valid_req_o, mem_rw_o, mem_addr_o, mem_data_o,
               grant_o, busy_o
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Arbitrates instruction-fetch and data-side line requests onto one AXI master front-end.
// Define ARB_ROUND_ROBIN_EN for round-robin; default build is fixed priority (D over I).
module mem_req_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 128
) (
    input logic              clk,
    input logic              rst,
    mem_req_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_I  = 2'd1,
        BUSY_D  = 2'd2,
        RELEASE = 2'd3
    } state_e;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_I    = 2'b01;
    localparam logic [1:0] GRANT_D    = 2'b10;

    state_e            state_q, state_d;
    logic              valid_q, valid_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_done_q, i_done_d;
    logic              d_done_q, d_done_d;
    logic [1:0]        grant_q, grant_d;
    logic              busy_q, busy_d;
    logic              pick_d;
    logic              over;
`ifdef ARB_ROUND_ROBIN_EN
    logic              last_d_q, last_d_d;
`endif

    // Next state, latched request and registered outputs
    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
        grant_d   = grant_q;
        pick_d    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_d_d  = last_d_q;
`endif
        over = rw_q ? bus.mem_wr_over_i : bus.mem_rd_over_i;

        case (state_q)
            IDLE: begin
                if (bus.i_req_i || bus.d_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
                    // On contention the port not served last wins
                    pick_d   = bus.d_req_i && (!bus.i_req_i || !last_d_q);
                    last_d_d = pick_d;
`else
                    pick_d   = bus.d_req_i;
`endif
                    valid_d = 1'b1;
                    if (pick_d) begin
                        state_d = BUSY_D;
                        rw_d    = bus.d_rw_i;
                        addr_d  = bus.d_addr_i;
                        wdata_d = bus.d_wdata_i;
                        grant_d = GRANT_D;
                    end else begin
                        state_d = BUSY_I;
                        rw_d    = 1'b0;
                        addr_d  = bus.i_addr_i;
                        wdata_d = '0;
                        grant_d = GRANT_I;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                // Only the completion matching the latched direction ends the transfer
                if (over) begin
                    state_d = RELEASE;
                    valid_d = 1'b0;
                    grant_d = GRANT_NONE;
                    if (state_q == BUSY_I) begin
                        i_done_d = 1'b1;
                        if (!rw_q) i_rdata_d = bus.mem_data_i;
                    end else begin
                        d_done_d = 1'b1;
                        if (!rw_q) d_rdata_d = bus.mem_data_i;
                    end
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            grant_q   <= GRANT_NONE;
            busy_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q  <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q  <= last_d_d;
`endif
        end
    end

    assign bus.mem_valid_req_o = valid_q;
    assign bus.mem_rw_o        = rw_q;
    assign bus.mem_addr_o      = addr_q;
    assign bus.mem_data_o      = wdata_q;
    assign bus.i_rdata_o       = i_rdata_q;
    assign bus.d_rdata_o       = d_rdata_q;
    assign bus.i_done_o        = i_done_q;
    assign bus.d_done_o        = d_done_q;
    assign bus.grant_o         = grant_q;
    assign bus.busy_o          = busy_q;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_mem_req_arbiter;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 128;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_req_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    mem_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Reference model: who was served last, and what each port last read
    bit                m_last_d;
    logic [DATA_W-1:0] m_i_rdata;
    logic [DATA_W-1:0] m_d_rdata;

    typedef struct {
        logic [1:0]        g_grant;
        logic              g_valid;
        logic              g_busy;
        int                valid_cycles;
        bit                early_done;
        logic              rw_and;
        logic              rw_or;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              o_done_i, o_done_d, o_valid, o_busy;
        logic [1:0]        o_grant;
        logic [DATA_W-1:0] o_rdata_i, o_rdata_d;
        logic              r_done_i, r_done_d, r_valid, r_busy;
        logic [1:0]        r_grant;
        logic [DATA_W-1:0] r_rdata_i, r_rdata_d;
    } obs_t;

    function automatic bit model_pick(input bit iq, input bit dq);
        if (iq && dq) return RR ? !m_last_d : 1'b1;
        return dq;
    endfunction

    task automatic model_commit(input bit win_d, input bit rw, input logic [DATA_W-1:0] rd);
        if (RR) m_last_d = win_d;
        if (!rw) begin
            if (win_d) m_d_rdata = rd;
            else       m_i_rdata = rd;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic apply_reset();
        bus.i_req_i = 1'b0; bus.i_addr_i = '0;
        bus.d_req_i = 1'b0; bus.d_rw_i = 1'b0; bus.d_addr_i = '0; bus.d_wdata_i = '0;
        bus.mem_data_i = '0; bus.mem_rd_over_i = 1'b0; bus.mem_wr_over_i = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m_last_d  = 1'b1;
        m_i_rdata = '0;
        m_d_rdata = '0;
    endtask

    // Drives one whole transaction and records what the arbiter showed at each phase
    task automatic txn(input bit iq, input bit dq, input logic [ADDR_W-1:0] ia,
                       input logic [ADDR_W-1:0] da, input bit drw, input logic [DATA_W-1:0] wd,
                       input logic [DATA_W-1:0] rd, input int lat, input bit stray,
                       input bit hold, input bit exp_rw, input bit rel_pulse, output obs_t o);
        bus.i_req_i = iq; bus.d_req_i = dq; bus.i_addr_i = ia; bus.d_addr_i = da;
        bus.d_rw_i = drw; bus.d_wdata_i = wd;
        tick();
        o.g_grant = bus.grant_o; o.g_valid = bus.mem_valid_req_o; o.g_busy = bus.busy_o;
        bus.i_addr_i = ~ia; bus.d_addr_i = ~da; bus.d_rw_i = ~drw; bus.d_wdata_i = ~wd;
        if (!hold) begin bus.i_req_i = 1'b0; bus.d_req_i = 1'b0; end
        o.valid_cycles = 0; o.early_done = 1'b0; o.rw_and = 1'b1; o.rw_or = 1'b0;
        for (int c = 0; c < lat; c++) begin
            if (bus.mem_valid_req_o === 1'b1) o.valid_cycles++;
            if (bus.i_done_o !== 1'b0 || bus.d_done_o !== 1'b0) o.early_done = 1'b1;
            o.rw_and = o.rw_and & bus.mem_rw_o;
            o.rw_or  = o.rw_or | bus.mem_rw_o;
            o.addr = bus.mem_addr_o; o.data = bus.mem_data_o;
            if (c == lat - 1) begin
                bus.mem_data_i = rd;
                if (exp_rw) bus.mem_wr_over_i = 1'b1; else bus.mem_rd_over_i = 1'b1;
            end else if (stray && c == 0) begin
                bus.mem_data_i = ~rd;
                if (exp_rw) bus.mem_rd_over_i = 1'b1; else bus.mem_wr_over_i = 1'b1;
            end
            tick();
            bus.mem_rd_over_i = 1'b0; bus.mem_wr_over_i = 1'b0;
        end
        o.o_done_i = bus.i_done_o; o.o_done_d = bus.d_done_o; o.o_valid = bus.mem_valid_req_o;
        o.o_busy = bus.busy_o; o.o_grant = bus.grant_o;
        o.o_rdata_i = bus.i_rdata_o; o.o_rdata_d = bus.d_rdata_o;
        bus.i_req_i = 1'b0; bus.d_req_i = 1'b0;
        if (rel_pulse) begin
            bus.mem_rd_over_i = 1'b1; bus.mem_wr_over_i = 1'b1; bus.mem_data_i = ~rd;
        end
        tick();
        bus.mem_rd_over_i = 1'b0; bus.mem_wr_over_i = 1'b0;
        o.r_done_i = bus.i_done_o; o.r_done_d = bus.d_done_o; o.r_valid = bus.mem_valid_req_o;
        o.r_busy = bus.busy_o; o.r_grant = bus.grant_o;
        o.r_rdata_i = bus.i_rdata_o; o.r_rdata_d = bus.d_rdata_o;
    endtask

    task automatic test_reset();
        logic [DATA_W*3+ADDR_W+8-1:0] all_out;
        apply_reset();
        rst = 1'b1;
        tick();
        all_out = {bus.i_rdata_o, bus.d_rdata_o, bus.mem_data_o, bus.mem_addr_o,
                   bus.i_done_o, bus.d_done_o, bus.mem_valid_req_o, bus.mem_rw_o,
                   bus.grant_o, bus.busy_o, 1'b0};
        checks++;
        if (all_out !== '0) begin errors++; $display("FAIL reset_outputs: got %0h expected 0", all_out); end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", bus.busy_o); end
    endtask

    task automatic test_i_read();
        obs_t o;
        logic [DATA_W-1:0] rd = {16{8'hA5}};
        txn(1'b1, 1'b0, 32'h0000_0100, '0, 1'b0, '0, rd, 4, 1'b0, 1'b0, 1'b0, 1'b0, o);
        model_commit(1'b0, 1'b0, rd);
        checks++; if (o.g_grant !== 2'b01) begin errors++; $display("FAIL iread_grant: got %b expected 01", o.g_grant); end
        checks++; if (o.valid_cycles != 4) begin errors++; $display("FAIL iread_valid_len: got %0d expected 4", o.valid_cycles); end
        checks++; if (o.addr !== 32'h0000_0100) begin errors++; $display("FAIL iread_addr: got %h expected 00000100", o.addr); end
        checks++; if (o.rw_or !== 1'b0) begin errors++; $display("FAIL iread_rw: got %b expected 0", o.rw_or); end
        checks++; if ({o.o_done_i, o.o_done_d} !== 2'b10) begin errors++; $display("FAIL iread_done: got %b expected 10", {o.o_done_i, o.o_done_d}); end
        checks++; if (o.o_rdata_i !== rd) begin errors++; $display("FAIL iread_rdata: got %h expected %h", o.o_rdata_i, rd); end
        checks++; if (o.o_grant !== 2'b00) begin errors++; $display("FAIL iread_grant_after: got %b expected 00", o.o_grant); end
        checks++; if (o.r_done_i !== 1'b0) begin errors++; $display("FAIL iread_done_width: got %b expected 0", o.r_done_i); end
    endtask

    task automatic test_d_write_mismatch();
        obs_t o;
        logic [DATA_W-1:0] wd = {8{16'h1234}};
        logic [DATA_W-1:0] rd = rand_data();
        txn(1'b0, 1'b1, '0, 32'h8000_0040, 1'b1, wd, rd, 4, 1'b1, 1'b0, 1'b1, 1'b0, o);
        model_commit(1'b1, 1'b1, rd);
        checks++; if (o.g_grant !== 2'b10) begin errors++; $display("FAIL dwr_grant: got %b expected 10", o.g_grant); end
        checks++; if (o.rw_and !== 1'b1) begin errors++; $display("FAIL dwr_rw_held: got %b expected 1", o.rw_and); end
        checks++; if (o.early_done !== 1'b0) begin errors++; $display("FAIL dwr_rd_over_ignored: got %b expected 0", o.early_done); end
        checks++; if (o.valid_cycles != 4) begin errors++; $display("FAIL dwr_valid_len: got %0d expected 4", o.valid_cycles); end
        checks++; if (o.addr !== 32'h8000_0040) begin errors++; $display("FAIL dwr_addr: got %h expected 80000040", o.addr); end
        checks++; if (o.data !== wd) begin errors++; $display("FAIL dwr_data: got %h expected %h", o.data, wd); end
        checks++; if ({o.o_done_i, o.o_done_d} !== 2'b01) begin errors++; $display("FAIL dwr_done: got %b expected 01", {o.o_done_i, o.o_done_d}); end
        checks++; if (o.o_rdata_d !== m_d_rdata) begin errors++; $display("FAIL dwr_rdata_kept: got %h expected %h", o.o_rdata_d, m_d_rdata); end
    endtask

    task automatic test_arbitration();
        obs_t o;
        bit seq [4];
        apply_reset();
        for (int k = 0; k < 4; k++) seq[k] = RR ? ((k % 2) == 1) : 1'b1;
        for (int k = 0; k < 4; k++) begin
            bit win_d = model_pick(1'b1, 1'b1);
            bit drw = 1'($urandom_range(0, 1));
            bit rw = win_d ? drw : 1'b0;
            logic [DATA_W-1:0] rd = rand_data();
            checks++; if (win_d != seq[k]) begin errors++; $display("FAIL arb_model_seq%0d: got %b expected %b", k, win_d, seq[k]); end
            txn(1'b1, 1'b1, $urandom, $urandom, drw, rand_data(), rd, 2, 1'b0, 1'b1, rw, 1'b0, o);
            model_commit(win_d, rw, rd);
            checks++; if (o.g_grant !== (seq[k] ? 2'b10 : 2'b01)) begin errors++; $display("FAIL arb_grant%0d: got %b expected %b", k, o.g_grant, seq[k] ? 2'b10 : 2'b01); end
            checks++; if ({o.o_done_i, o.o_done_d} !== {!seq[k], seq[k]}) begin errors++; $display("FAIL arb_done%0d: got %b expected %b", k, {o.o_done_i, o.o_done_d}, {!seq[k], seq[k]}); end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2;
        logic [DATA_W-1:0] rd1 = rand_data();
        logic [DATA_W-1:0] rd2 = rand_data();
        txn(1'b1, 1'b0, $urandom, '0, 1'b0, '0, rd1, 1, 1'b0, 1'b0, 1'b0, 1'b0, o1);
        model_commit(1'b0, 1'b0, rd1);
        txn(1'b1, 1'b0, $urandom, '0, 1'b0, '0, rd2, 1, 1'b0, 1'b0, 1'b0, 1'b0, o2);
        model_commit(1'b0, 1'b0, rd2);
        checks++; if ({o1.o_valid, o1.o_busy, o1.o_grant} !== 4'b0100) begin errors++; $display("FAIL b2b_release_cycle: got %b expected 0100", {o1.o_valid, o1.o_busy, o1.o_grant}); end
        checks++; if ({o1.r_valid, o1.r_busy} !== 2'b00) begin errors++; $display("FAIL b2b_release_len: got %b expected 00", {o1.r_valid, o1.r_busy}); end
        checks++; if (o2.g_valid !== 1'b1) begin errors++; $display("FAIL b2b_next_valid: got %b expected 1", o2.g_valid); end
        checks++; if (o2.o_rdata_i !== rd2) begin errors++; $display("FAIL b2b_rdata2: got %h expected %h", o2.o_rdata_i, rd2); end
    endtask

    task automatic test_idle_over();
        bus.mem_data_i = rand_data();
        bus.mem_rd_over_i = 1'b1; bus.mem_wr_over_i = 1'b1;
        tick();
        bus.mem_rd_over_i = 1'b0; bus.mem_wr_over_i = 1'b0;
        checks++; if ({bus.i_done_o, bus.d_done_o, bus.busy_o} !== 3'b000) begin errors++; $display("FAIL idle_over_ignored: got %b expected 000", {bus.i_done_o, bus.d_done_o, bus.busy_o}); end
        checks++; if (bus.i_rdata_o !== m_i_rdata) begin errors++; $display("FAIL idle_over_rdata: got %h expected %h", bus.i_rdata_o, m_i_rdata); end
    endtask

    task automatic test_reset_mid();
        logic [DATA_W*3+ADDR_W+8-1:0] all_out;
        bus.d_req_i = 1'b1; bus.d_rw_i = 1'b1; bus.d_addr_i = 32'h40; bus.d_wdata_i = rand_data();
        tick();
        bus.d_req_i = 1'b0;
        checks++; if (bus.grant_o !== 2'b10) begin errors++; $display("FAIL rstmid_busy_d: got %b expected 10", bus.grant_o); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_last_d = 1'b1; m_i_rdata = '0; m_d_rdata = '0;
        all_out = {bus.i_rdata_o, bus.d_rdata_o, bus.mem_data_o, bus.mem_addr_o,
                   bus.i_done_o, bus.d_done_o, bus.mem_valid_req_o, bus.mem_rw_o,
                   bus.grant_o, bus.busy_o, 1'b0};
        checks++; if (all_out !== '0) begin errors++; $display("FAIL rstmid_outputs: got %0h expected 0", all_out); end
        bus.mem_wr_over_i = 1'b1;
        tick();
        bus.mem_wr_over_i = 1'b0;
        checks++; if ({bus.d_done_o, bus.busy_o, bus.grant_o} !== 4'b0000) begin errors++; $display("FAIL rstmid_late_over: got %b expected 0000", {bus.d_done_o, bus.busy_o, bus.grant_o}); end
    endtask

    task automatic test_addr_hold();
        logic [DATA_W-1:0] rd = rand_data();
        bus.d_req_i = 1'b1; bus.d_rw_i = 1'b0; bus.d_addr_i = 32'h10;
        tick();
        bus.d_req_i = 1'b0; bus.d_addr_i = 32'h20;
        tick();
        checks++; if (bus.mem_addr_o !== 32'h10) begin errors++; $display("FAIL addr_hold: got %h expected 00000010", bus.mem_addr_o); end
        bus.mem_data_i = rd; bus.mem_rd_over_i = 1'b1;
        tick();
        bus.mem_rd_over_i = 1'b0;
        model_commit(1'b1, 1'b0, rd);
        checks++; if ({bus.d_done_o, bus.d_rdata_o} !== {1'b1, m_d_rdata}) begin errors++; $display("FAIL addr_hold_done: got %b/%h expected 1/%h", bus.d_done_o, bus.d_rdata_o, m_d_rdata); end
        tick();
    endtask

    task automatic test_random();
        obs_t o;
        for (int n = 0; n < 40; n++) begin
            int sel = $urandom_range(1, 3);
            bit iq = sel[0];
            bit dq = sel[1];
            logic [ADDR_W-1:0] ia = $urandom;
            logic [ADDR_W-1:0] da = $urandom;
            bit drw = 1'($urandom_range(0, 1));
            logic [DATA_W-1:0] wd = rand_data();
            logic [DATA_W-1:0] rd = rand_data();
            int lat = $urandom_range(1, 6);
            bit win_d = model_pick(iq, dq);
            bit rw = win_d ? drw : 1'b0;
            txn(iq, dq, ia, da, drw, wd, rd, lat, 1'($urandom_range(0, 1)), 1'b0, rw,
                1'($urandom_range(0, 1)), o);
            model_commit(win_d, rw, rd);
            checks++; if (o.g_grant !== (win_d ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rnd%0d_grant: got %b expected %b", n, o.g_grant, win_d ? 2'b10 : 2'b01); end
            checks++; if (o.addr !== (win_d ? da : ia)) begin errors++; $display("FAIL rnd%0d_addr: got %h expected %h", n, o.addr, win_d ? da : ia); end
            checks++; if ({o.rw_and, o.rw_or} !== {rw, rw}) begin errors++; $display("FAIL rnd%0d_rw: got %b expected %b", n, {o.rw_and, o.rw_or}, {rw, rw}); end
            if (rw) begin
                checks++; if (o.data !== wd) begin errors++; $display("FAIL rnd%0d_wdata: got %h expected %h", n, o.data, wd); end
            end
            checks++; if (o.valid_cycles != lat || o.early_done) begin errors++; $display("FAIL rnd%0d_busy_phase: got %0d/%b expected %0d/0", n, o.valid_cycles, o.early_done, lat); end
            checks++; if ({o.o_done_i, o.o_done_d} !== {!win_d, win_d}) begin errors++; $display("FAIL rnd%0d_done: got %b expected %b", n, {o.o_done_i, o.o_done_d}, {!win_d, win_d}); end
            checks++; if ({o.o_rdata_i, o.o_rdata_d} !== {m_i_rdata, m_d_rdata}) begin errors++; $display("FAIL rnd%0d_rdata: got %h/%h expected %h/%h", n, o.o_rdata_i, o.o_rdata_d, m_i_rdata, m_d_rdata); end
            checks++; if ({o.o_valid, o.o_busy, o.o_grant} !== 4'b0100) begin errors++; $display("FAIL rnd%0d_release: got %b expected 0100", n, {o.o_valid, o.o_busy, o.o_grant}); end
            checks++; if ({o.r_done_i, o.r_done_d, o.r_busy, o.r_grant} !== 5'b0) begin errors++; $display("FAIL rnd%0d_idle: got %b expected 00000", n, {o.r_done_i, o.r_done_d, o.r_busy, o.r_grant}); end
            checks++; if ({o.r_rdata_i, o.r_rdata_d} !== {m_i_rdata, m_d_rdata}) begin errors++; $display("FAIL rnd%0d_rdata_hold: got %h/%h expected %h/%h", n, o.r_rdata_i, o.r_rdata_d, m_i_rdata, m_d_rdata); end
        end
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_d_write_mismatch();
        test_arbitration();
        test_back_to_back();
        test_idle_over();
        test_reset_mid();
        test_addr_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
